// File: rtl/bakraid_pcm_fifo.sv
// Stereo PCM rate-adaptation FIFO: captures samples at the CEN-derived 44.1 kHz rate and
// replays them at a CLK-derived output rate, holding the last sample when starved.
module bakraid_pcm_fifo #(
  parameter int W      = 16,
  parameter int DIV    = 384,
  parameter int OUTDIV = 2000,
  parameter int AW     = 3
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          CEN16p9344,
  input  logic [W-1:0]  IN_L,
  input  logic [W-1:0]  IN_R,
  output logic          IN_STB,
  output logic [W-1:0]  OUT_L,
  output logic [W-1:0]  OUT_R,
  output logic          OUT_SAMPLE,
  output logic [AW:0]   LEVEL,
  output logic          RUNNING,
  output logic          OVERRUN,
  output logic          UNDERRUN,
  input  logic          CLR_FLAGS
);

  localparam int D  = 1 << AW;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW = (OUTDIV > 1) ? $clog2(OUTDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUTDIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(D);
  localparam logic [AW:0]   LVL_HALF = (AW + 1)'(D / 2);

  typedef enum logic {S_PRIME = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [OW-1:0]   ocnt_q, ocnt_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic [W-1:0]    out_l_q, out_l_d, out_r_q, out_r_d;
  logic            stb_q, sample_q, ovr_q, ovr_d, und_q, und_d;
  logic [2*W-1:0]  mem_q [D];

  logic push, slot, empty, full, do_pop, starve, drop;

  always_comb begin
    push   = CEN16p9344 && (div_q == DIV_LAST);
    slot   = (ocnt_q == OUT_LAST);
    empty  = (level_q == '0);
    full   = (level_q == LVL_FULL);
    do_pop = (state_q == S_RUN) && slot && !empty;
    starve = (state_q == S_RUN) && slot && empty;
    // A push into a full FIFO with no pop to make room evicts the oldest entry.
    drop   = push && full && !do_pop;

    div_d  = div_q;
    if (CEN16p9344) div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    ocnt_d = slot ? '0 : ocnt_q + OW'(1);
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = (do_pop || drop) ? rptr_q + AW'(1) : rptr_q;

    level_d = level_q;
    case ({push && !drop, do_pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (do_pop) {out_l_d, out_r_d} = mem_q[rptr_q];

    state_d = state_q;
    case (state_q)
      S_PRIME: if (level_d >= LVL_HALF) state_d = S_RUN;
      S_RUN:   if (starve) state_d = S_PRIME;
      default: state_d = S_PRIME;
    endcase

    ovr_d = drop   ? 1'b1 : (CLR_FLAGS ? 1'b0 : ovr_q);
    und_d = starve ? 1'b1 : (CLR_FLAGS ? 1'b0 : und_q);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= S_PRIME;
      div_q    <= '0;
      ocnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      stb_q    <= 1'b0;
      sample_q <= 1'b0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ocnt_q   <= ocnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      stb_q    <= push;
      sample_q <= slot;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {IN_L, IN_R};
  end

  assign IN_STB     = stb_q;
  assign OUT_L      = out_l_q;
  assign OUT_R      = out_r_q;
  assign OUT_SAMPLE = sample_q;
  assign LEVEL      = level_q;
  assign RUNNING    = (state_q == S_RUN);
  assign OVERRUN    = ovr_q;
  assign UNDERRUN   = und_q;

endmodule

// File: tb/tb_bakraid_pcm_fifo.sv
// Bench for bakraid_pcm_fifo: a small fast instance checked against a queue model,
// plus a default-parameter instance for the divide-by-384 reset-release timing.
module tb_bakraid_pcm_fifo;
  localparam int W = 16, SDIV = 4, SOUT = 40, AW = 3, D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cen, clr;
  logic [W-1:0]  in_l, in_r, out_l, out_r;
  logic          stb, osmp, running, ovr, und;
  logic [AW:0]   level;

  logic          b_rst_n;
  logic [W-1:0]  b_out_l, b_out_r;
  logic          b_stb, b_osmp, b_running, b_ovr, b_und;
  logic [AW:0]   b_level;

  bakraid_pcm_fifo #(.W(W), .DIV(SDIV), .OUTDIV(SOUT), .AW(AW)) dut (
    .CLK(clk), .RESETn(rst_n), .CEN16p9344(cen), .IN_L(in_l), .IN_R(in_r),
    .IN_STB(stb), .OUT_L(out_l), .OUT_R(out_r), .OUT_SAMPLE(osmp), .LEVEL(level),
    .RUNNING(running), .OVERRUN(ovr), .UNDERRUN(und), .CLR_FLAGS(clr));

  bakraid_pcm_fifo #(.W(W), .DIV(384), .OUTDIV(2000), .AW(AW)) dut_big (
    .CLK(clk), .RESETn(b_rst_n), .CEN16p9344(1'b1), .IN_L(16'h1234), .IN_R(16'h5678),
    .IN_STB(b_stb), .OUT_L(b_out_l), .OUT_R(b_out_r), .OUT_SAMPLE(b_osmp), .LEVEL(b_level),
    .RUNNING(b_running), .OVERRUN(b_ovr), .UNDERRUN(b_und), .CLR_FLAGS(1'b0));

  int n_cmp = 0, n_bad = 0;

  // Reference model: a queue of stereo pairs plus sample-rate bookkeeping.
  logic [31:0]  m_q[$];
  int           m_div, m_ocnt;
  bit           m_run, m_ov, m_un, m_stb, m_smp;
  logic [W-1:0] m_l, m_r;

  function automatic void m_reset();
    m_q.delete();
    m_div = 0; m_ocnt = 0; m_run = 0; m_ov = 0; m_un = 0; m_stb = 0; m_smp = 0;
    m_l = '0; m_r = '0;
  endfunction

  function automatic void m_step(bit c, logic [W-1:0] l, logic [W-1:0] r, bit cl);
    bit push, slot, set_ov, set_un;
    logic [31:0] e;
    set_ov = 0; set_un = 0;
    push = c && (m_div == SDIV - 1);
    if (c) m_div = (m_div + 1) % SDIV;
    slot = (m_ocnt == SOUT - 1);
    m_ocnt = (m_ocnt + 1) % SOUT;
    if (slot && m_run) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_l = e[31:16]; m_r = e[15:0];
      end else set_un = 1;
    end
    if (push) begin
      if (m_q.size() == D) begin
        void'(m_q.pop_front());
        set_ov = 1;
      end
      m_q.push_back({l, r});
    end
    if (m_run) m_run = !set_un;
    else       m_run = (m_q.size() >= D / 2);
    m_ov  = set_ov || (m_ov && !cl);
    m_un  = set_un || (m_un && !cl);
    m_stb = push;
    m_smp = slot;
  endfunction

  task automatic tick(input bit c, input logic [W-1:0] l, input logic [W-1:0] r, input bit cl);
    cen = c; in_l = l; in_r = r; clr = cl;
    @(posedge clk); #1;
    m_step(c, l, r, cl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cen = 0; clr = 0; in_l = '0; in_r = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_big_release();
    b_rst_n = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    for (int n = 1; n <= 1600; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (b_stb !== (n % 384 == 0)) begin
        n_bad++; $display("FAIL big_in_stb edge=%0d got %0b want %0b", n, b_stb, (n % 384 == 0));
      end
      n_cmp++;
      if (b_level !== 4'(n / 384)) begin
        n_bad++; $display("FAIL big_level edge=%0d got %0d want %0d", n, b_level, n / 384);
      end
    end
    n_cmp++;
    if (b_running !== 1'b1) begin
      n_bad++; $display("FAIL big_running got %0b want 1", b_running);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({stb, osmp, running, ovr, und} !== 5'b0 || level !== '0 || out_l !== '0 || out_r !== '0) begin
      n_bad++;
      $display("FAIL reset_state got stb=%0b smp=%0b run=%0b ov=%0b un=%0b lvl=%0d l=%h r=%h want all 0",
               stb, osmp, running, ovr, und, level, out_l, out_r);
    end
  endtask

  task automatic test_priming();
    logic [W-1:0] first;
    first = '0;
    do_reset();
    for (int e = 1; e <= 44; e++) begin
      tick(e % 2 == 0, 16'h0101 * 16'((e + 7) / 8), 16'h0202 * 16'((e + 7) / 8), 0);
      if (e == 40) first = out_l;
      n_cmp++;
      if (out_l !== m_l || level !== 4'(m_q.size()) || running !== m_run) begin
        n_bad++;
        $display("FAIL priming e=%0d got l=%h lvl=%0d run=%0b want l=%h lvl=%0d run=%0b",
                 e, out_l, level, running, m_l, m_q.size(), m_run);
      end
    end
    n_cmp++;
    if (first !== 16'h0101) begin
      n_bad++; $display("FAIL priming_first_pop got %h want 0101", first);
    end
  endtask

  task automatic test_overrun_underrun();
    do_reset();
    for (int e = 1; e <= 36; e++) tick(1, 16'((e + 3) / 4), 16'((e + 3) / 4 + 100), 0);
    n_cmp++;
    if (level !== 4'd8 || ovr !== 1'b1 || running !== 1'b1) begin
      n_bad++; $display("FAIL overrun got lvl=%0d ov=%0b run=%0b want 8 1 1", level, ovr, running);
    end
    for (int e = 37; e <= 360; e++) begin
      tick(0, '0, '0, 0);
      if (e % 40 == 0 && e <= 320) begin
        n_cmp++;
        if (out_l !== 16'(e / 40 + 1) || out_r !== 16'(e / 40 + 101) || osmp !== 1'b1) begin
          n_bad++;
          $display("FAIL drain e=%0d got l=%0d r=%0d smp=%0b want l=%0d r=%0d smp=1",
                   e, out_l, out_r, osmp, e / 40 + 1, e / 40 + 101);
        end
      end
    end
    n_cmp++;
    if (out_l !== 16'd9 || und !== 1'b1 || running !== 1'b0 || osmp !== 1'b1 || level !== '0) begin
      n_bad++;
      $display("FAIL underrun got l=%0d un=%0b run=%0b smp=%0b lvl=%0d want 9 1 0 1 0",
               out_l, und, running, osmp, level);
    end
    tick(0, '0, '0, 1);
    n_cmp++;
    if (und !== 1'b0 || ovr !== 1'b0) begin
      n_bad++; $display("FAIL clr_flags got un=%0b ov=%0b want 0 0", und, ovr);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int e = 1; e <= 32; e++) tick(1, 16'h1000 + 16'((e + 3) / 4), 16'h2000, 0);
    n_cmp++;
    if (level !== 4'd8 || running !== 1'b1) begin
      n_bad++; $display("FAIL fill got lvl=%0d run=%0b want 8 1", level, running);
    end
    for (int e = 33; e <= 36; e++) tick(0, '0, '0, 0);
    for (int e = 37; e <= 40; e++) tick(1, 16'hBEEF, 16'hCAFE, 0);
    n_cmp++;
    if (level !== 4'd8 || ovr !== 1'b0 || out_l !== 16'h1001 || osmp !== 1'b1 || stb !== 1'b1) begin
      n_bad++;
      $display("FAIL push_pop_full got lvl=%0d ov=%0b l=%h smp=%0b stb=%0b want 8 0 1001 1 1",
               level, ovr, out_l, osmp, stb);
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    p = 8;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) p = $urandom_range(0, 8);
      tick($urandom_range(0, 7) < p, 16'($urandom), 16'($urandom), $urandom_range(0, 49) == 0);
      n_cmp++;
      if (stb !== m_stb || osmp !== m_smp || out_l !== m_l || out_r !== m_r ||
          level !== 4'(m_q.size()) || running !== m_run || ovr !== m_ov || und !== m_un) begin
        n_bad++;
        $display("FAIL random i=%0d got stb=%0b smp=%0b l=%h r=%h lvl=%0d run=%0b ov=%0b un=%0b want %0b %0b %h %h %0d %0b %0b %0b",
                 i, stb, osmp, out_l, out_r, level, running, ovr, und,
                 m_stb, m_smp, m_l, m_r, m_q.size(), m_run, m_ov, m_un);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 100; i++) tick(1, 16'($urandom), 16'($urandom), 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_l !== '0 || out_r !== '0 || level !== '0 || running !== 1'b0 || stb !== 1'b0 || osmp !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got l=%h r=%h lvl=%0d run=%0b stb=%0b smp=%0b want all 0",
               out_l, out_r, level, running, stb, osmp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    for (int e = 1; e <= 8; e++) begin
      tick(1, 16'h5555, 16'hAAAA, 0);
      n_cmp++;
      if (stb !== (e % 4 == 0)) begin
        n_bad++; $display("FAIL reset_mid_stb e=%0d got %0b want %0b", e, stb, (e % 4 == 0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; b_rst_n = 1'b0; cen = 0; clr = 0; in_l = '0; in_r = '0;
    m_reset();
    test_big_release();
    test_reset();
    test_priming();
    test_overrun_underrun();
    test_full_push_pop();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
